// File: rtl/store_buffer_bypass_pkg.sv
// Shared constants for the MEM-stage store buffer.
// Word-offset width, default sizes, pointer-width helper.
package store_buffer_bypass_pkg;

    localparam int WORD_LSB   = 2;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: entry arrays, valid bits, head/tail/count.
// Ports: clk, reset, push/pop + push_addr/push_data, flat
// valid/entry_word/entry_data, head pointer and head entry, full/empty.
module store_buffer_fifo
    import store_buffer_bypass_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int PW    = ptr_w(DEPTH),
    localparam int WW    = ADDR_W - WORD_LSB
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ADDR_W-1:0]       push_addr,
    input  logic [DATA_W-1:0]       push_data,
    output logic [DEPTH-1:0]        valid,
    output logic [DEPTH*WW-1:0]     entry_word,
    output logic [DEPTH*DATA_W-1:0] entry_data,
    output logic [PW-1:0]           head,
    output logic [ADDR_W-1:0]       head_addr,
    output logic [DATA_W-1:0]       head_data,
    output logic                    full,
    output logic                    empty
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [PW:0]       count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    // Pop clears before push sets: when full with a
    // same-edge drain, head == tail and the slot stays valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            if (push && !pop)
                count_q <= count_q + (PW+1)'(1);
            else if (pop && !push)
                count_q <= count_q - (PW+1)'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign entry_word[i*WW +: WW] =
            addr_q[i][ADDR_W-1:WORD_LSB];
        assign entry_data[i*DATA_W +: DATA_W] = data_q[i];
    end

    assign valid     = valid_q;
    assign head      = head_q;
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/store_buffer_bypass.sv
// MEM-stage posted-write buffer with sw->lw forwarding.
// Ports: clk, reset, ex_mem_* access, dmem_* memory port,
// load_data to MEM/WB, stall to the front end, empty.
module store_buffer_bypass
    import store_buffer_bypass_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int PW    = ptr_w(DEPTH),
    localparam int WW    = ADDR_W - WORD_LSB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_mem_memwrite,
    input  logic              ex_mem_memread,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              empty
);

    logic                    push;
    logic                    drain_fire;
    logic                    full;
    logic [DEPTH-1:0]        valid;
    logic [DEPTH*WW-1:0]     entry_word;
    logic [DEPTH*DATA_W-1:0] entry_data;
    logic [PW-1:0]           head;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [WW-1:0]           ld_word;
    logic [PW-1:0]           idx;
    logic                    hit;
    logic [DATA_W-1:0]       hit_data;

    store_buffer_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (drain_fire),
        .push_addr  (ex_mem_addr),
        .push_data  (ex_mem_wdata),
        .valid      (valid),
        .entry_word (entry_word),
        .entry_data (entry_data),
        .head       (head),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty)
    );

    assign ld_word = ex_mem_addr[ADDR_W-1:WORD_LSB];

    // Walk oldest to youngest from head; the last hit
    // wins, so the entry nearest tail forwards.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] &&
                entry_word[int'(idx)*WW +: WW] == ld_word) begin
                hit      = 1'b1;
                hit_data = entry_data[int'(idx)*DATA_W +: DATA_W];
            end
        end
    end

    // Load owns the port; drains only in non-load cycles.
    assign drain_fire = !empty && !ex_mem_memread && dmem_ready;
    assign push       = ex_mem_memwrite && (!full || drain_fire);
    assign stall      = ex_mem_memwrite && full && !drain_fire;
    assign dmem_we    = drain_fire;

    assign dmem_addr  = ex_mem_memread ? ex_mem_addr :
                        (empty ? '0 : head_addr);
    assign dmem_wdata = empty ? '0 : head_data;
    assign load_data  = hit ? hit_data : dmem_rdata;

endmodule

// File: tb/tb_store_buffer_bypass.sv
// Scoreboard bench for store_buffer_bypass.
// Reference: ordered store list + word memory.
module tb_store_buffer_bypass;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] dmem_rdata;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        empty;

    store_buffer_bypass dut (
        .clk             (clk),
        .reset           (reset),
        .ex_mem_memwrite (wr),
        .ex_mem_memread  (rd),
        .ex_mem_addr     (addr),
        .ex_mem_wdata    (wdata),
        .dmem_ready      (rdy),
        .dmem_rdata      (dmem_rdata),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .load_data       (load_data),
        .stall           (stall),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Data memory behind the port
    logic [31:0] mem [64];
    assign dmem_rdata = mem[dmem_addr[7:2]];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (dmem_we) begin
            mem[dmem_addr[7:2]] <= dmem_wdata;
        end
    end

    always @(posedge clk)
        if (!reset)
            assert (!(wr && rd)) else $error("illegal wr+rd");

    typedef struct {
        logic        we;
        logic        stall;
        logic        empty;
        logic [31:0] a;
        logic [31:0] d;
    } cyc_t;

    cyc_t        cq [$];
    logic [31:0] lq [$];
    int          errs   = 0;
    int          checks = 0;
    bit          mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare each cycle's outputs against the queue
    always @(negedge clk) begin : mon
        cyc_t r;
        if (mon_en && cq.size() > 0) begin
            r = cq.pop_front();
            chk("stall", 32'(stall), 32'(r.stall));
            chk("empty", 32'(empty), 32'(r.empty));
            chk("dmem_we", 32'(dmem_we), 32'(r.we));
            if (r.we && dmem_we) begin
                chk("drain_addr", dmem_addr, r.a);
                chk("drain_data", dmem_wdata, r.d);
            end
            if (rd) begin
                if (lq.size() == 0) begin
                    errs++;
                    checks++;
                    $display("FAIL load_q: got load, expected none");
                end else begin
                    chk("load_data", load_data, lq.pop_front());
                end
            end
        end
    end

    // Reference model
    logic [31:0] sq_a [$];
    logic [31:0] sq_d [$];
    logic [31:0] ref_mem [64];
    bit          last_stall;

    task automatic model_clear();
        sq_a.delete();
        sq_d.delete();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic step(input bit w, input bit r_, input logic [31:0] a,
                        input logic [31:0] d, input bit rr);
        cyc_t        c;
        logic [31:0] ld;
        bit          dr;
        @(posedge clk);
        #1;
        wr = w; rd = r_; addr = a; wdata = d; rdy = rr;
        dr      = (sq_a.size() != 0) && !r_ && rr;
        c.we    = dr;
        c.empty = (sq_a.size() == 0);
        c.stall = w && (sq_a.size() == 4) && !dr;
        c.a     = dr ? sq_a[0] : 32'h0;
        c.d     = dr ? sq_d[0] : 32'h0;
        if (r_) begin
            ld = ref_mem[a[7:2]];
            foreach (sq_a[i])
                if (sq_a[i][31:2] == a[31:2]) ld = sq_d[i];
            lq.push_back(ld);
        end
        cq.push_back(c);
        if (dr) begin
            ref_mem[sq_a[0][7:2]] = sq_d[0];
            void'(sq_a.pop_front());
            void'(sq_d.pop_front());
        end
        if (w && !c.stall) begin
            sq_a.push_back(a);
            sq_d.push_back(d);
        end
        last_stall = c.stall;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, rr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pa, pd;
        bit          pend;
        int          op;
        reset = 1'b1; wr = 0; rd = 0; addr = 0; wdata = 0; rdy = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1;

        // basic bypass
        step(1, 0, 32'h10, 32'hAAAA, 0);
        step(0, 1, 32'h10, 32'h0, 0);
        // youngest of duplicates
        step(1, 0, 32'h20, 32'h1, 0);
        step(1, 0, 32'h20, 32'h2, 0);
        step(0, 1, 32'h20, 32'h0, 0);
        idle(3, 1);
        // full -> stall, then drain+enqueue same edge
        for (int i = 0; i < 4; i++)
            step(1, 0, 32'(i * 4), 32'h100 + 32'(i), 0);
        step(1, 0, 32'h30, 32'h55, 0);
        step(1, 0, 32'h30, 32'h55, 0);
        step(1, 0, 32'h30, 32'h55, 1);
        // loads block drains
        idle(2, 1);
        step(0, 1, 32'h30, 32'h0, 1);
        step(0, 1, 32'h8, 32'h0, 1);
        step(0, 1, 32'h4, 32'h0, 1);
        idle(3, 1);
        // wrap-around with interleaved drains
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 32'h40 + 32'(4 * (k % 6)),
                 32'h700 + 32'(k), bit'(k % 2));
            while (last_stall)
                step(1, 0, 32'h40 + 32'(4 * (k % 6)),
                     32'h700 + 32'(k), 1);
        end
        step(0, 1, 32'h40 + 32'(4 * (9 % 6)), 32'h0, 0);
        idle(6, 1);
        // async reset with 3 pending, one at 0x0
        step(1, 0, 32'h0, 32'hDEAD, 0);
        step(1, 0, 32'h4, 32'hBEEF, 0);
        step(1, 0, 32'h8, 32'hCAFE, 0);
        @(posedge clk);
        #1;
        mon_en = 0;
        wr = 0; rd = 0; rdy = 0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_we", 32'(dmem_we), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        model_clear();
        cq.delete();
        lq.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1;
        step(0, 1, 32'h0, 32'h0, 1);

        // random traffic
        pend = 0; pa = 0; pd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                op = int'($urandom_range(0, 3));
                pa = 32'($urandom_range(0, 15)) * 4 +
                     32'($urandom_range(0, 3));
                pd = $urandom;
            end else begin
                op = 0;
            end
            if (op < 2)
                step(1, 0, pa, pd, ($urandom % 3) != 0);
            else if (op == 2)
                step(0, 1, pa, 32'h0, ($urandom % 3) != 0);
            else
                idle(1, ($urandom % 3) != 0);
            pend = last_stall;
        end
        idle(8, 1);
        @(negedge clk);
        #1;
        chk("final_empty", 32'(empty), 32'd1);
        chk("left_cq", 32'(cq.size()), 32'd0);
        chk("left_lq", 32'(lq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
